parking_button_conditioner: RTL

Front-end stage for the parking meter: takes the six raw push-button levels (add1–add4, rst1, rst2), synchronizes and debounces each one, and converts every debounced press into exactly one single-cycle pulse. Pulses are arbitrated so at most one command reaches the meter per clock. Outputs drive the meter's add1..add4/rst1/rst2 inputs directly; both blocks share one clock.

---
 rtl/parking_button_conditioner.sv | 74 +++++++
 1 files changed

// File: rtl/parking_button_conditioner.sv
// parking_button_conditioner: synchronizes, debounces and edge-detects six buttons, then arbitrates them into one-hot single-cycle commands.
// Define AUTO_REPEAT_EN to make held add buttons re-issue after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
module parking_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 20,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_PERIOD = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_add1,
  input  logic btn_add2,
  input  logic btn_add3,
  input  logic btn_add4,
  input  logic btn_rst1,
  input  logic btn_rst2,
  output logic add1,
  output logic add2,
  output logic add3,
  output logic add4,
  output logic rst1,
  output logic rst2
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= 2**CNT_W || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("parking_button_conditioner: invalid parameters");
  end
  // Bit order doubles as priority: bit 0 (rst1) wins, bit 5 (add4) loses.
  logic [5:0] raw, s1, s2, stable, stable_d, rep_event, new_event, pending, grant, cmd;
  logic [CNT_W-1:0] cnt [6];
  assign raw = {btn_add4, btn_add3, btn_add2, btn_add1, btn_rst2, btn_rst1};
  assign new_event = (stable & ~stable_d) | rep_event;
  assign grant = pending & (~pending + 6'd1);
  assign {add4, add3, add2, add1, rst2, rst1} = cmd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      stable_d <= '0;
      pending <= '0;
      cmd <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      stable_d <= stable;
      pending <= (pending & ~grant) | new_event;
      cmd <= grant;
      for (int i = 0; i < 6; i++) begin
        cnt[i] <= (s2[i] == stable[i] || cnt[i] == DB_LAST) ? '0 : cnt[i] + 1'b1;
        stable[i] <= (s2[i] != stable[i] && cnt[i] == DB_LAST) ? s2[i] : stable[i];
      end
    end
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_AT = CNT_W'(REPEAT_DELAY);
  // Reloading to DELAY-PERIOD+1 makes the next hit land exactly PERIOD cycles later.
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
  logic [CNT_W-1:0] hold [4];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < 4; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        hold[i] <= !stable[i+2] ? '0 : hold[i] == RPT_AT ? RPT_RELOAD : hold[i] + 1'b1;
    end
  always_comb begin
    rep_event = '0;
    for (int i = 0; i < 4; i++) rep_event[i+2] = stable[i+2] && hold[i] == RPT_AT;
  end
`else
  assign rep_event = '0;
`endif
endmodule
